aes128_core: RTL and testbench

// - Iterative AES-128 encryption engine (FIPS-197, encrypt only), one round per clock.
// - Accepts a 128-bit key and plaintext on a start strobe and returns the ciphertext with a done strobe.
// - Standalone crypto datapath; the host holds inputs and polls or waits on done.

---
 rtl/aes128_core.sv | 160 ++++++++++++++++
 tb/tb_aes128_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_core.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Optional busy output is enabled by defining AES_CORE_BUSY_EN.
module aes128_core (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
`ifdef AES_CORE_BUSY_EN
  output logic         busy,
`endif
  output logic         done,
  output logic [127:0] ciphertext
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1B;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte 4c+r sits at row r, column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    t  = {rk[23:0], rk[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t       state_q, state_d;
  logic [127:0] s_q, s_d, rk_q, rk_d, ct_q, ct_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;
  logic [127:0] nk, sr, round_out;

  assign nk        = next_key(rk_q, rcon(rnd_q));
  assign sr        = shift_rows(sub_bytes(s_q));
  assign round_out = ((rnd_q == 4'd10) ? sr : mix_columns(sr)) ^ nk;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = plaintext ^ key;
          rk_d    = key;
          rnd_d   = 4'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d   = round_out;
        rk_d  = nk;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          ct_d    = round_out;
          done_d  = 1'b1;
          rnd_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

  assign done       = done_q;
  assign ciphertext = ct_q;
`ifdef AES_CORE_BUSY_EN
  assign busy       = (state_q == RUN);
`endif

endmodule

// File: tb/tb_aes128_core.sv
// Self-checking bench for aes128_core: transaction-level AES model plus FIPS-197 literal vectors.
module tb_aes128_core;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] plaintext = '0;
  logic         done;
  logic [127:0] ciphertext;
`ifdef AES_CORE_BUSY_EN
  logic         busy;
`endif

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128_core dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key        (key),
    .plaintext  (plaintext),
`ifdef AES_CORE_BUSY_EN
    .busy       (busy),
`endif
    .done       (done),
    .ciphertext (ciphertext)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box derived from its algebraic definition: GF(2^8) inverse then affine map.
  logic [7:0] sbox_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1B;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
    logic [7:0] ks [176];
    logic [7:0] st [16];
    logic [7:0] t  [16];
    logic [7:0] tw [4];
    logic [7:0] rc = 8'h01;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) ks[i] = k[127-8*i -: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tw[j] = ks[4*(i-1)+j];
      if (i % 4 == 0) begin
        for (int j = 0; j < 4; j++) tw[j] = sbox_m[ks[4*(i-1)+((j+1)%4)]];
        tw[0] ^= rc;
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) ks[4*i+j] = ks[4*(i-4)+j] ^ tw[j];
    end
    for (int i = 0; i < 16; i++) st[i] = p[127-8*i -: 8] ^ ks[i];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = sbox_m[st[4*((c+row)%4)+row]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          if (r < 10)
            st[4*c+row] = gmul(t[4*c+row], 8'h02) ^ gmul(t[4*c+(row+1)%4], 8'h03)
                        ^ t[4*c+(row+2)%4] ^ t[4*c+(row+3)%4];
          else
            st[4*c+row] = t[4*c+row];
      for (int i = 0; i < 16; i++) st[i] ^= ks[16*r+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // Transaction model: accept when idle, deliver the block 10 clocks later.
  logic         m_run, m_done;
  int           m_rem;
  logic [127:0] m_pend, m_ct;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_rem  <= 0;
      m_pend <= '0;
      m_ct   <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_run) begin
        if (start) begin
          m_run  <= 1'b1;
          m_rem  <= 10;
          m_pend <= aes_model(key, plaintext);
        end
      end else begin
        if (m_rem == 1) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
          m_ct   <= m_pend;
        end
        m_rem <= m_rem - 1;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_done", {127'b0, done}, {127'b0, m_done});
    check("cyc_ciphertext", ciphertext, m_ct);
`ifdef AES_CORE_BUSY_EN
    check("cyc_busy", {127'b0, busy}, {127'b0, m_run});
`endif
  end

  task automatic run(input logic [127:0] k, input logic [127:0] p, input bit mid, output int lat);
    @(negedge clk);
    key = k; plaintext = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
      if (mid && lat == 4) begin
        start = 1'b1; key = ~k; plaintext = ~p;
      end else begin
        start = 1'b0;
      end
    end
    if (lat >= 30) check("done_timeout", 128'(lat), 128'd10);
  endtask

  int lat;

  initial begin
    build_sbox();
    check("sbox_00", {120'b0, sbox_m[0]}, 128'h63);
    check("sbox_53", {120'b0, sbox_m[8'h53]}, 128'hed);
    check("model_v1", aes_model(K1, P1), C1);
    check("model_v2", aes_model(K2, P2), C2);

    repeat (2) @(negedge clk);
    check("rst_done", {127'b0, done}, 128'd0);
    check("rst_ct", ciphertext, 128'd0);
    reset = 1'b0;

    run(K1, P1, 1'b0, lat);
    check("v1_latency", 128'(lat), 128'd10);
    check("v1_ct", ciphertext, C1);
    @(negedge clk);
    check("v1_done_drop", {127'b0, done}, 128'd0);

    run(K2, P2, 1'b1, lat);
    check("v2_latency", 128'(lat), 128'd10);
    check("v2_ct", ciphertext, C2);
    repeat (12) @(negedge clk);
    check("v2_ct_hold", ciphertext, C2);

    run(128'd0, 128'd0, 1'b0, lat);
    check("v3_ct", ciphertext, C3);
    @(negedge clk);
    check("v3_done_drop", {127'b0, done}, 128'd0);

    @(negedge clk);
    key = K1; plaintext = P1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_done", {127'b0, done}, 128'd0);
    check("abort_ct", ciphertext, 128'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done_ct", ciphertext, 128'd0);
    run(K2, P2, 1'b0, lat);
    check("after_abort_latency", 128'(lat), 128'd10);
    check("after_abort_ct", ciphertext, C2);

    @(negedge clk);
    key = K1; plaintext = P1; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 30);
    check("b2b_first_latency", 128'(lat), 128'd11);
    check("b2b_first_ct", ciphertext, C1);
    key = K2; plaintext = P2;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_second_latency", 128'(lat), 128'd10);
    check("b2b_second_ct", ciphertext, C2);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
